simon_ctrl: RTL and testbench
=============================

SIMON_CTRL -- requirements
Module: simon_ctrl

Interface
REQ-001 Parameter MAX_SEQ, default 15, is the sequence length that wins the game (range 2..255).
REQ-002 Parameter ON_CYC, default 4, is the number of cycles each playback LED is lit.
REQ-003 Parameter OFF_CYC, default 2, is the number of dark cycles after each playback LED.
REQ-004 Parameter TIMEOUT, default 64, is the number of idle user-turn cycles before failure.
REQ-005 Port clk, input, 1 bit: the single clock; all state changes on posedge.
REQ-006 Port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 Port sw, input, 4 bits: user color switches, bit i = color i.
REQ-008 Port led, output, 4 bits: one-hot color display.
REQ-009 Port seq_len, output, 8 bits: current round length.
REQ-010 Port seq_idx, output, 8 bits: next element the user must enter.
REQ-011 Port best, output, 8 bits: longest fully completed round.
REQ-012 Port user_turn, output, 1 bit: high in USER state.
REQ-013 Port fail, output, 1 bit: high in FAIL state.
REQ-014 Port win, output, 1 bit: high in WIN state.

Function
REQ-015 States SHALL be IDLE, PLAY_ON, PLAY_OFF, USER, FAIL and WIN.
REQ-016 Colors SHALL come from an 8-bit Fibonacci LFSR (taps 8,6,5,4; seed 8'hA5); color = lfsr[1:0]; the LFSR advances once per consumed element.
REQ-017 The LFSR SHALL reload its seed on every entry to PLAY_ON from IDLE or USER, and on entry to USER, so element k is identical in playback and user turn.
REQ-018 IDLE SHALL last exactly 1 cycle and then go to PLAY_ON with seq_idx=0.
REQ-019 PLAY_ON SHALL drive led=onehot(color) for ON_CYC cycles, then go to PLAY_OFF.
REQ-020 PLAY_OFF SHALL drive led=0 for OFF_CYC cycles, then increment seq_idx; if seq_idx reaches seq_len it goes to USER with seq_idx=0, otherwise it returns to PLAY_ON.
REQ-021 In USER, led SHALL equal sw; a press is a cycle where sw was 0 on the previous cycle and sw is now nonzero.
REQ-022 A press that is one-hot and equal to onehot(color) SHALL increment seq_idx, advance the LFSR and clear the timeout counter.
REQ-023 A press that is not one-hot, or not equal to onehot(color), SHALL go to FAIL with seq_idx unchanged.
REQ-024 A correct press of the last element SHALL set best = max(best, seq_len); if seq_len==MAX_SEQ it goes to WIN, otherwise seq_len increments and the next state is PLAY_ON.
REQ-025 FAIL and WIN SHALL hold, with led=0, until rst.
REQ-026 Counters SHALL be 8-bit unsigned and SHALL never wrap, because MAX_SEQ is at most 255.

Reset
REQ-027 With rst high at a posedge, the next state SHALL be IDLE and the outputs SHALL be led=0, seq_len=1, seq_idx=0, best=0, user_turn=0, fail=0, win=0.
REQ-028 Reset mid-playback or mid-user-turn SHALL abort immediately, including clearing best.
REQ-029 The first cycle after reset is released SHALL be the single IDLE cycle.

Configuration
REQ-030 With SIMON_TIMEOUT_EN defined, a counter SHALL run in USER and go to FAIL after TIMEOUT consecutive cycles without a press.
REQ-031 Without SIMON_TIMEOUT_EN, the counter SHALL be absent and USER SHALL wait indefinitely.

Structure
REQ-032 Package simon_pkg SHALL hold the state enum, the LFSR seed, the tap constant and the color width.
REQ-033 Sub-module simon_lfsr SHALL implement the LFSR with ports clk, rst, load, step and q[7:0].

Verification
REQ-034 Reset test: rst held 4 cycles -> led=0, seq_len=1, best=0; IDLE lasts 1 cycle; led is nonzero from the 2nd cycle for 4 cycles.
REQ-035 Playback timing: seq_len=1 with defaults -> user_turn=1 exactly 1+4+2 cycles after reset release.
REQ-036 Correct play with MAX_SEQ=15 -> seq_len steps 1..15, best=14 before the final round, then win=1 and best=15.
REQ-037 Wrong color at round 3, element 2 -> fail=1 on the next cycle, seq_idx=2, best=2, and state held for 100 cycles.
REQ-038 Non-one-hot press sw=4'b0011 at round 1 -> fail=1.
REQ-039 Timeout with SIMON_TIMEOUT_EN: no press for 64 cycles -> fail=1 on cycle 64, not on cycle 63; without the macro -> no fail after 1000 cycles.

Source files
------------

// File: rtl/simon_pkg.sv
// Shared types and constants for the Simon game controller.
package simon_pkg;

  // Width of a color index; four colors are encoded in two bits.
  localparam int COLOR_W = 2;

  // Value loaded into the color LFSR at the start of every pass over the sequence.
  localparam logic [7:0] LFSR_SEED = 8'hA5;

  // Feedback taps 8,6,5,4 expressed as a mask over bit positions 7,5,4,3.
  localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PLAY_ON,
    S_PLAY_OFF,
    S_USER,
    S_FAIL,
    S_WIN
  } state_e;

  // Expand a color index into the one-hot LED / switch pattern.
  function automatic logic [3:0] onehot(input logic [COLOR_W-1:0] c);
    return 4'b0001 << c;
  endfunction

endpackage

// File: rtl/simon_lfsr.sv
// 8-bit Fibonacci LFSR that produces the color sequence.
// load has priority over step so a pass can restart on the same cycle it would advance.
module simon_lfsr
  import simon_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       step,
  output logic [7:0] q
);

  // Shift left with the tap parity fed into bit 0.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses <= so every register samples pre-edge values.
    if (rst || load) begin
      q <= LFSR_SEED;
    end else if (step) begin
      q <= {q[6:0], ^(q & LFSR_TAPS)};
    end
  end

endmodule

// File: rtl/simon_ctrl.sv
// Simon memory-game controller: plays back a growing LFSR color sequence,
// then checks the user's switch presses against it.
// Optional: define SIMON_TIMEOUT_EN to fail the user turn after TIMEOUT idle cycles.
module simon_ctrl
  import simon_pkg::*;
#(
  parameter int MAX_SEQ = 15,
  parameter int ON_CYC  = 4,
  parameter int OFF_CYC = 2,
  parameter int TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] sw,
  output logic [3:0] led,
  output logic [7:0] seq_len,
  output logic [7:0] seq_idx,
  output logic [7:0] best,
  output logic       user_turn,
  output logic       fail,
  output logic       win
);

  state_e     state_q;
  logic [7:0] seq_len_q, seq_idx_q, best_q, ph_cnt_q;
  logic [3:0] sw_prev_q;
  logic       user_turn_q, fail_q, win_q;

  logic [7:0] lfsr_q;
  logic       lfsr_load, lfsr_step;
  logic [3:0] want;
  logic       press, press_ok, last_elem, on_done, off_done, timed_out;

  simon_lfsr u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .load (lfsr_load),
    .step (lfsr_step),
    .q    (lfsr_q)
  );

  // Only the low bits select a color; the rest exist to lengthen the sequence.
  logic unused_lfsr_bits;
  assign unused_lfsr_bits = ^lfsr_q[7:COLOR_W];

  assign want      = onehot(lfsr_q[COLOR_W-1:0]);
  assign press     = (sw_prev_q == 4'd0) && (sw != 4'd0);
  // Equality with a one-hot pattern already rejects multi-bit presses.
  assign press_ok  = press && (sw == want);
  assign last_elem = (seq_idx_q + 8'd1) == seq_len_q;
  assign on_done   = ph_cnt_q == 8'(ON_CYC - 1);
  assign off_done  = ph_cnt_q == 8'(OFF_CYC - 1);

`ifdef SIMON_TIMEOUT_EN
  logic [7:0] idle_cnt_q;

  // Count consecutive press-free user cycles; held at zero outside the user turn.
  always_ff @(posedge clk) begin
    if (rst || state_q != S_USER || press) begin
      idle_cnt_q <= 8'd0;
    end else begin
      idle_cnt_q <= idle_cnt_q + 8'd1;
    end
  end

  assign timed_out = idle_cnt_q == 8'(TIMEOUT - 1);
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT == 0);
  assign timed_out      = 1'b0;
`endif

  // Restart the color sequence when a playback pass or a user turn begins;
  // otherwise advance once per consumed element.
  assign lfsr_load = (state_q == S_IDLE)
                  || (state_q == S_PLAY_OFF && off_done && last_elem)
                  || (state_q == S_USER && press_ok && last_elem);
  assign lfsr_step = (state_q == S_PLAY_OFF && off_done && !last_elem)
                  || (state_q == S_USER && press_ok && !last_elem);

  // Previous switch value for press (rising from all-zero) detection.
  always_ff @(posedge clk) begin
    if (rst) sw_prev_q <= 4'd0;
    else     sw_prev_q <= sw;
  end

  // Game FSM with its counters and registered status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      seq_len_q   <= 8'd1;
      seq_idx_q   <= 8'd0;
      best_q      <= 8'd0;
      ph_cnt_q    <= 8'd0;
      user_turn_q <= 1'b0;
      fail_q      <= 1'b0;
      win_q       <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_q   <= S_PLAY_ON;
          seq_idx_q <= 8'd0;
          ph_cnt_q  <= 8'd0;
        end
        S_PLAY_ON: begin
          if (on_done) begin
            ph_cnt_q <= 8'd0;
            state_q  <= S_PLAY_OFF;
          end else begin
            ph_cnt_q <= ph_cnt_q + 8'd1;
          end
        end
        S_PLAY_OFF: begin
          if (off_done) begin
            ph_cnt_q <= 8'd0;
            if (last_elem) begin
              state_q     <= S_USER;
              seq_idx_q   <= 8'd0;
              user_turn_q <= 1'b1;
            end else begin
              state_q   <= S_PLAY_ON;
              seq_idx_q <= seq_idx_q + 8'd1;
            end
          end else begin
            ph_cnt_q <= ph_cnt_q + 8'd1;
          end
        end
        S_USER: begin
          if (press_ok) begin
            if (last_elem) begin
              user_turn_q <= 1'b0;
              if (seq_len_q > best_q) best_q <= seq_len_q;
              if (seq_len_q == 8'(MAX_SEQ)) begin
                state_q <= S_WIN;
                win_q   <= 1'b1;
              end else begin
                state_q   <= S_PLAY_ON;
                seq_len_q <= seq_len_q + 8'd1;
                seq_idx_q <= 8'd0;
                ph_cnt_q  <= 8'd0;
              end
            end else begin
              seq_idx_q <= seq_idx_q + 8'd1;
            end
          end else if (press || timed_out) begin
            state_q     <= S_FAIL;
            user_turn_q <= 1'b0;
            fail_q      <= 1'b1;
          end
        end
        S_FAIL, S_WIN: ; // terminal until reset
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // LED source depends on the phase: the sequence color, the user's switches, or dark.
  always_comb begin
    // NOTE: default first so no path leaves led unassigned (no latch).
    led = 4'd0;
    case (state_q)
      S_PLAY_ON: led = want;
      S_USER:    led = sw;
      default:   led = 4'd0;
    endcase
  end

  assign seq_len   = seq_len_q;
  assign seq_idx   = seq_idx_q;
  assign best      = best_q;
  assign user_turn = user_turn_q;
  assign fail      = fail_q;
  assign win       = win_q;

endmodule

// File: tb/tb_simon_ctrl.sv
// Directed self-checking bench for simon_ctrl with default parameters.
module tb_simon_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] sw  = 4'd0;
  logic [3:0] led;
  logic [7:0] seq_len, seq_idx, best;
  logic       user_turn, fail, win;

  int n_checks = 0;
  int n_errors = 0;

  logic [1:0] col [0:15];

  simon_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .sw        (sw),
    .led       (led),
    .seq_len   (seq_len),
    .seq_idx   (seq_idx),
    .best      (best),
    .user_turn (user_turn),
    .fail      (fail),
    .win       (win)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; observe outputs 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    sw  = 4'd0;
    repeat (4) tick();
    rst = 1'b0;
  endtask

  task automatic wait_user(input string tag);
    int n = 0;
    while (!user_turn && n < 2000) begin
      tick();
      n++;
    end
    check(tag, user_turn, 1);
  endtask

  task automatic press(input logic [3:0] v);
    sw = v;
    #1;
    check("led_follows_sw", led, v);
    tick();
    sw = 4'd0;
    tick();
  endtask

  task automatic play_round(input int r);
    wait_user($sformatf("wait_user_r%0d", r));
    check($sformatf("seq_len_r%0d", r), seq_len, r);
    check($sformatf("best_at_r%0d", r), best, r - 1);
    for (int k = 0; k < r; k++) press(4'b0001 << col[k]);
  endtask

  initial begin
    logic [7:0] s;
    logic [1:0] wc;

    // Reference color sequence: taps 8,6,5,4 -> bits 7,5,4,3, shifted in at bit 0.
    s = 8'hA5;
    for (int k = 0; k < 16; k++) begin
      col[k] = s[1:0];
      s = {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    end

    // Reset values after 4 cycles of rst.
    repeat (4) tick();
    check("rst_led", led, 0);
    check("rst_seq_len", seq_len, 1);
    check("rst_seq_idx", seq_idx, 0);
    check("rst_best", best, 0);
    check("rst_flags", {user_turn, fail, win}, 3'b000);
    rst = 1'b0;
    check("idle_led", led, 0);

    // IDLE 1 cycle, 4 lit cycles of color 1 (seed A5), 2 dark, then the user turn.
    for (int i = 1; i <= 7; i++) begin
      tick();
      check($sformatf("play_led_c%0d", i), led, (i <= 4) ? 4'b0010 : 4'b0000);
      check($sformatf("user_turn_c%0d", i), user_turn, (i == 7) ? 1 : 0);
    end

    // Full correct game to MAX_SEQ=15.
    for (int r = 1; r <= 14; r++) play_round(r);
    check("no_win_yet", win, 0);
    play_round(15);
    check("win", win, 1);
    check("best_final", best, 15);
    check("win_led", led, 0);
    check("win_user_turn", user_turn, 0);

    // Reset clears best and the round counter.
    rst = 1'b1;
    tick();
    check("rst_after_win_best", best, 0);
    check("rst_after_win_len", seq_len, 1);
    check("rst_after_win_win", win, 0);

    // Reset mid-playback aborts immediately.
    do_reset();
    tick();
    tick();
    check("mid_play_led_on", led, 4'b0010);
    rst = 1'b1;
    tick();
    check("mid_play_rst_led", led, 0);
    check("mid_play_rst_idx", seq_idx, 0);

    // Wrong color at round 3, element 2.
    do_reset();
    play_round(1);
    play_round(2);
    wait_user("wait_user_fail_r3");
    press(4'b0001 << col[0]);
    press(4'b0001 << col[1]);
    wc = col[2] + 2'd1;
    sw = 4'b0001 << wc;
    tick();
    sw = 4'd0;
    check("wrong_fail", fail, 1);
    check("wrong_idx", seq_idx, 2);
    check("wrong_best", best, 2);
    check("wrong_user_turn", user_turn, 0);
    for (int i = 0; i < 100; i++) begin
      sw = 4'($urandom_range(0, 15));
      tick();
    end
    sw = 4'd0;
    #1;
    check("hold_fail", fail, 1);
    check("hold_idx", seq_idx, 2);
    check("hold_led", led, 0);
    check("hold_win", win, 0);

    // Non-one-hot press at round 1.
    do_reset();
    wait_user("wait_user_multi");
    sw = 4'b0011;
    tick();
    sw = 4'd0;
    check("multi_fail", fail, 1);

    // Idle user turn.
    do_reset();
    wait_user("wait_user_timeout");
`ifdef SIMON_TIMEOUT_EN
    repeat (63) tick();
    check("timeout_c63", fail, 0);
    tick();
    check("timeout_c64", fail, 1);
`else
    repeat (1000) tick();
    check("no_timeout_fail", fail, 0);
    check("no_timeout_turn", user_turn, 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
